cpu_inst_encode: RTL
====================

CPU_INST_ENCODE -- requirements
Module: cpu_inst_encode

Interface
REQ-001 SHALL have parameter: TAG_WIDTH, 8, width of the output change-tag.
REQ-002 SHALL have port: i_clock  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: i_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: i_valid in 1 request present; o_ready out 1 request accepted when i_valid&o_ready.
REQ-005 SHALL have port: i_format  in  3  0=R,1=I,2=S,3=B,4=U,5=J,6=LI (load-immediate pseudo-op),7=invalid.
REQ-006 SHALL have ports: i_opcode in 7, i_funct3 in 3, i_funct7 in 7; instruction fields.
REQ-007 SHALL have ports: i_rd, i_rs1, i_rs2  in  5 each  register indices.
REQ-008 SHALL have port: i_imm  in  32  signed immediate (U: full 32-bit value).
REQ-009 SHALL have port: i_stall  in  1  downstream hold; freezes output and FSM.
REQ-010 SHALL have ports: o_tag out TAG_WIDTH, changes exactly once per new instruction; o_instruction out 32, encoded word valid whenever o_tag changes.
REQ-011 SHALL have port: o_error  out  1  one-cycle pulse on rejected request.

Function
REQ-012 SHALL implement FSM states S_IDLE and S_LI_LO; o_ready = (state==S_IDLE) & !i_stall.
REQ-013 SHALL, on accept in cycle N of a valid request, present o_instruction and o_tag+1 from cycle N+1 (latency 1).
REQ-014 SHALL encode R: {funct7,rs2,rs1,funct3,rd,opcode}.
REQ-015 SHALL encode I: {imm[11:0],rs1,funct3,rd,opcode}; requires imm in [-2048,2047].
REQ-016 SHALL encode S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; range as I.
REQ-017 SHALL encode B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; requires imm even and in [-4096,4094].
REQ-018 SHALL encode U: {imm[31:12],rd,opcode}; requires imm[11:0]==0.
REQ-019 SHALL encode J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; requires imm even and in [-2^20,2^20-2].
REQ-020 SHALL ignore i_opcode/funct fields for LI, using LUI=0110111 and ADDI=0010011/funct3 000.
REQ-021 SHALL, for LI with imm in [-2048,2047], emit single ADDI rd,x0,imm; state stays S_IDLE.
REQ-022 SHALL, for other LI, emit LUI rd,(imm+0x800)[31:12] (32-bit wrap add); if imm[11:0]!=0 go S_LI_LO, else stay S_IDLE.
REQ-023 SHALL, in S_LI_LO with !i_stall, emit ADDI rd,rd,imm[11:0] (latched), tag+1, return S_IDLE.
REQ-024 SHALL latch rd and imm[11:0] at LI accept; input changes afterwards have no effect.
REQ-025 SHALL, on format 7 or range/alignment violation, consume request, pulse o_error in cycle N+1, leave o_tag and o_instruction unchanged.
REQ-026 SHALL hold o_tag, o_instruction and state while i_stall=1; no request accepted.
REQ-027 SHALL increment o_tag modulo 2^TAG_WIDTH (all-ones wraps to 0).
REQ-028 SHALL never change o_tag more than once per cycle.

Reset
REQ-029 SHALL, while i_reset=1, force o_tag=0, o_instruction=0, o_error=0, state=S_IDLE, o_ready=0.
REQ-030 SHALL discard any pending ADDI of an LI when reset is asserted in S_LI_LO.
REQ-031 SHALL allow o_ready=1 in the first cycle after reset deasserts (if !i_stall).

Verification
REQ-032 SHALL cover: R, op 0110011, f3 0, f7 0, rd 3, rs1 1, rs2 2 -> o_instruction 0x002081B3, o_tag 0->1 next cycle.
REQ-033 SHALL cover: LI rd 5, imm 0x12345FFF -> 0x123462B7 then 0xFFF28293 on consecutive cycles, o_ready low during second.
REQ-034 SHALL cover: B, op 1100011, rs1 1, rs2 2, imm -4 -> 0xFE208EE3; same with imm 3 -> o_error pulse, tag unchanged.
REQ-035 SHALL cover: i_stall=1 for 3 cycles in S_LI_LO -> outputs frozen, ADDI emitted cycle after stall drops.
REQ-036 SHALL cover: TAG_WIDTH=4, 16 back-to-back I requests -> tag 15 wraps to 0, one increment per cycle.
REQ-037 SHALL cover: reset in S_LI_LO -> o_tag 0, o_instruction 0, ADDI never emitted.

Source files
------------

// File: rtl/cpu_inst_encode_if.sv
// Request/response bundle between an instruction producer and the encoder.
// Master drives the request fields; slave returns the encoded word.
interface cpu_inst_encode_if #(
  parameter int TAG_WIDTH = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [2:0]           i_format;
  logic [6:0]           i_opcode;
  logic [2:0]           i_funct3;
  logic [6:0]           i_funct7;
  logic [4:0]           i_rd;
  logic [4:0]           i_rs1;
  logic [4:0]           i_rs2;
  logic [31:0]          i_imm;
  logic                 i_stall;
  logic [TAG_WIDTH-1:0] o_tag;
  logic [31:0]          o_instruction;
  logic                 o_error;

  modport master (
    output i_valid,
    output i_format,
    output i_opcode,
    output i_funct3,
    output i_funct7,
    output i_rd,
    output i_rs1,
    output i_rs2,
    output i_imm,
    output i_stall,
    input  o_ready,
    input  o_tag,
    input  o_instruction,
    input  o_error
  );

  modport slave (
    input  i_valid,
    input  i_format,
    input  i_opcode,
    input  i_funct3,
    input  i_funct7,
    input  i_rd,
    input  i_rs1,
    input  i_rs2,
    input  i_imm,
    input  i_stall,
    output o_ready,
    output o_tag,
    output o_instruction,
    output o_error
  );
endinterface

// File: rtl/cpu_inst_encode.sv
// RV32 instruction encoder: packs decoded fields into a 32-bit word,
// expands the LI pseudo-op into LUI(+ADDI) and flags malformed requests.
module cpu_inst_encode #(
  parameter int TAG_WIDTH = 8
) (
  input logic              i_clock,
  input logic              i_reset,
  cpu_inst_encode_if.slave bus
);

  localparam logic [2:0] F_R  = 3'd0;
  localparam logic [2:0] F_I  = 3'd1;
  localparam logic [2:0] F_S  = 3'd2;
  localparam logic [2:0] F_B  = 3'd3;
  localparam logic [2:0] F_U  = 3'd4;
  localparam logic [2:0] F_J  = 3'd5;
  localparam logic [2:0] F_LI = 3'd6;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  typedef enum logic {
    S_IDLE,
    S_LI_LO
  } state_e;

  state_e               state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [31:0]          instr_q, instr_d;
  logic                 err_q, err_d;
  logic [4:0]           rd_q, rd_d;
  logic [11:0]          lo_q, lo_d;

  logic        accept;
  logic        ready;
  logic [31:0] imm;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic        lo_zero;
  logic [19:0] li_hi;
  logic        enc_ok;
  logic        li_split;
  logic [31:0] enc_word;
  logic [31:0] addi_lo;

  logic is_r, is_i, is_s, is_b;
  logic is_u, is_j, is_li;

  assign imm = bus.i_imm;

  // Sign-range tests: upper bits must all equal the sign bit.
  assign fits12  = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13  = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21  = (&imm[31:20]) | ~(|imm[31:20]);
  assign lo_zero = ~(|imm[11:0]);

  // Upper part rounded so the sign-extended low ADDI lands on imm.
  assign li_hi = imm[31:12] + {19'd0, imm[11]};

  assign is_r  = bus.i_format == F_R;
  assign is_i  = bus.i_format == F_I;
  assign is_s  = bus.i_format == F_S;
  assign is_b  = bus.i_format == F_B;
  assign is_u  = bus.i_format == F_U;
  assign is_j  = bus.i_format == F_J;
  assign is_li = bus.i_format == F_LI;

  assign ready  = ~i_reset
                & (state_q == S_IDLE)
                & ~bus.i_stall;
  assign accept = bus.i_valid & ready;

  assign addi_lo = {lo_q, rd_q, 3'b000,
                    rd_q, OP_ADDI};

  always_comb begin
    enc_ok   = 1'b0;
    li_split = 1'b0;
    enc_word = 32'd0;
    unique case (1'b1)
      is_r: begin
        enc_ok   = 1'b1;
        enc_word = {bus.i_funct7, bus.i_rs2,
                    bus.i_rs1, bus.i_funct3,
                    bus.i_rd, bus.i_opcode};
      end
      is_i: begin
        enc_ok   = fits12;
        enc_word = {imm[11:0], bus.i_rs1,
                    bus.i_funct3, bus.i_rd,
                    bus.i_opcode};
      end
      is_s: begin
        enc_ok   = fits12;
        enc_word = {imm[11:5], bus.i_rs2,
                    bus.i_rs1, bus.i_funct3,
                    imm[4:0], bus.i_opcode};
      end
      is_b: begin
        enc_ok   = fits13 & ~imm[0];
        enc_word = {imm[12], imm[10:5],
                    bus.i_rs2, bus.i_rs1,
                    bus.i_funct3, imm[4:1],
                    imm[11], bus.i_opcode};
      end
      is_u: begin
        enc_ok   = lo_zero;
        enc_word = {imm[31:12], bus.i_rd,
                    bus.i_opcode};
      end
      is_j: begin
        enc_ok   = fits21 & ~imm[0];
        enc_word = {imm[20], imm[10:1],
                    imm[11], imm[19:12],
                    bus.i_rd, bus.i_opcode};
      end
      is_li: begin
        enc_ok = 1'b1;
        if (fits12) begin
          enc_word = {imm[11:0], 5'd0, 3'b000,
                      bus.i_rd, OP_ADDI};
        end else begin
          li_split = ~lo_zero;
          enc_word = {li_hi, bus.i_rd, OP_LUI};
        end
      end
      default: begin
        enc_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    instr_d = instr_q;
    err_d   = 1'b0;
    rd_d    = rd_q;
    lo_d    = lo_q;
    if (state_q == S_LI_LO) begin
      if (!bus.i_stall) begin
        instr_d = addi_lo;
        tag_d   = tag_q + TAG_WIDTH'(1);
        state_d = S_IDLE;
      end
    end else if (accept) begin
      if (enc_ok) begin
        instr_d = enc_word;
        tag_d   = tag_q + TAG_WIDTH'(1);
        if (li_split) begin
          state_d = S_LI_LO;
          rd_d    = bus.i_rd;
          lo_d    = imm[11:0];
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
      rd_q    <= 5'd0;
      lo_q    <= 12'd0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_tag         = tag_q;
  assign bus.o_instruction = instr_q;
  assign bus.o_error       = err_q;

endmodule
